issue_queue_scheduler: RTL
==========================

Name: issue_queue_scheduler

Overview:
- Sits between InstructionDecode and the execution units of the dual-issue OTTER.
- Accepts up to two task_t per cycle in program order and holds them in a collapsing queue.
- Tracks register readiness with a 32-entry scoreboard and snoops the writeback bus to capture late source operands.
- Each cycle, issues at most one ready task to the ALU port and one to the MEM port.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 4.
CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
VALID_0  in  1  TASK_0 present (older)
VALID_1  in  1  TASK_1 present (younger)
TASK_0  in  task_t  decoded task, slot 0
TASK_1  in  task_t  decoded task, slot 1
ACCEPT_0  out  1  TASK_0 taken this cycle (combinational)
ACCEPT_1  out  1  TASK_1 taken this cycle (combinational)
regWrite  in  1  writeback strobe
regWrite_addr  in  5  writeback register
WB_rfIn  in  32  writeback data
FLUSH  in  1  discard all unissued entries
ALU_VALID  out  1  ALU_TASK valid
ALU_READY  in  1  ALU accepts
ALU_TASK  out  task_t  oldest ready non-memory task
MEM_VALID  out  1  MEM_TASK valid
MEM_READY  in  1  MEM unit accepts
MEM_TASK  out  task_t  oldest memory task, when ready
COUNT  out  CNT_W  occupied entries

Behaviour:
- Reset (async, RST_N=0):
  - all entry valid bits cleared; scoreboard busy[31:0] cleared.
  - COUNT=0; ALU_VALID=MEM_VALID=0.
- Entry contents: task_t, valid, rs1_rdy, rs2_rdy.
  - Index 0 is always the oldest entry.
  - Removals collapse younger entries toward index 0.
  - Inserts fill the lowest free indices, TASK_0 before TASK_1.
- Acceptance (in order):
  - ACCEPT_0 = VALID_0 & free>=1 & !FLUSH & !(TASK_0.rd_used & rd!=0 & busy[rd]).
  - ACCEPT_1 = ACCEPT_0 & VALID_1 & free>=2 & no WAW against busy and against TASK_0.rd.
  - free is evaluated before this cycle's issues (no same-cycle slot reuse).
- Scoreboard:
  - set busy[rd] on accept when rd_used & rd!=0.
  - clear busy[regWrite_addr] on regWrite.
  - x0 is never busy.
  - When a set and a clear hit the same register in one cycle, the set wins.
- Source readiness at insert: rsN_rdy = !rsN_used | rsN==0 | !busy[rsN] | (regWrite & regWrite_addr==rsN).
  - On a writeback hit, capture WB_rfIn: rs1 into A; rs2 into rs2_data, and also into B when opcode is OP or BRANCH.
  - TASK_1 sourcing TASK_0.rd is inserted not-ready.
- Snoop: every cycle, each valid not-ready source matching regWrite_addr (regWrite=1, addr!=0) captures as above and sets its rdy bit.
- ALU select:
  - candidate set = oldest valid entry with opcode not LOAD/STORE and both rdy bits set.
  - ALU_VALID/ALU_TASK are combinational from registered state.
  - the entry is removed on ALU_VALID & ALU_READY.
- MEM select:
  - only the oldest valid LOAD/STORE entry is considered, so memory stays in program order.
  - MEM_VALID is high when that entry's rdy bits are both set; removed on MEM_VALID & MEM_READY.
- Latency:
  - an accepted task is eligible for issue no earlier than the next cycle.
  - a snooped operand makes its entry eligible the cycle after the capture.
- Simultaneous events: two removals and two inserts in one cycle are legal; COUNT updates by (+inserts − removals).
- Full: ACCEPT_0=0 when COUNT==DEPTH; ACCEPT_1=0 when COUNT>=DEPTH-1.
- FLUSH (synchronous, one cycle):
  - invalidates all entries and suppresses this cycle's accepts and issues.
  - clears busy[rd] for every flushed entry with rd_used.
  - busy bits of already-issued tasks are retained; their writebacks clear them.
- Reset mid-operation wins over all events.

Decomposition:
- cpu_types package additions:
  - iq_entry_t struct (task_t plus valid and rdy bits).
  - is_mem(opcode_t) function.
  - B_FROM_RS2(opcode_t) function.
- Sub-module reg_scoreboard: busy vector; two set ports, one clear port, flush-clear mask; exposes busy[ ] lookups.

Test Plan:
1. Reset, then TASK_0=ADDI x1 and TASK_1=ADD x2,x1,x3 both valid, queue empty.
   - Required: both accepted; next cycle ALU_VALID with ADDI.
   - ADD waits until regWrite x1=0x5, then issues with A=0x5.
2. Fill 8 entries of ADD x0-free dependents with ALU_READY=0.
   - Required: COUNT=8, ACCEPT_0=0.
   - Raise ALU_READY: one entry leaves per cycle, oldest first.
3. LW x4 ready and ADD x5,x6,x7 ready, same cycle, both READY=1.
   - Required: both issue in that cycle; COUNT drops by 2.
4. WAW: busy[x8] set by an issued op; present ADDI x8.
   - Required: ACCEPT_0=0 until regWrite x8, then accepted the same cycle as the writeback.
5. Insert with same-cycle regWrite x9=0xDEAD to a source rs1=x9.
   - Required: entry inserted ready with A=0xDEAD.
6. FLUSH with 3 entries, two writing x10 and x11.
   - Required: COUNT=0 next cycle; busy[10]=busy[11]=0; issued-op busy bits retained.

Source files
------------

// File: rtl/issue_queue_scheduler_pkg.sv
// Shared types for the dual-issue OTTER issue queue: decoded task, queue entry
// and the opcode helpers used for port steering and operand capture.
package issue_queue_scheduler_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_used;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] pc;
        logic [31:0] A;
        logic [31:0] B;
        logic [31:0] rs2_data;
    } task_t;

    typedef struct packed {
        task_t t;
        logic  valid;
        logic  rs1_rdy;
        logic  rs2_rdy;
    } iq_entry_t;

    function automatic logic is_mem(input opcode_t op);
        return (op == LOAD) || (op == STORE);
    endfunction

    // Only register-register ALU ops and branches take their B operand from rs2.
    function automatic logic B_FROM_RS2(input opcode_t op);
        return (op == OP) || (op == BRANCH);
    endfunction

endpackage

// File: rtl/issue_queue_scheduler_scoreboard.sv
// Register busy scoreboard: two set ports, one writeback clear port and a
// flush-clear mask. A set beats a clear on the same register; x0 never busy.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set0_en,
    input  logic [4:0]  set0_addr,
    input  logic        set1_en,
    input  logic [4:0]  set1_addr,
    input  logic        clr_en,
    input  logic [4:0]  clr_addr,
    input  logic [31:0] flush_mask,
    output logic [31:0] busy
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        busy_d = busy_d & ~flush_mask;
        if (set0_en) busy_d[set0_addr] = 1'b1;
        if (set1_en) busy_d[set1_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/issue_queue_scheduler.sv
// Collapsing issue queue for the dual-issue OTTER: in-order insert of up to two
// tasks, writeback snooping, one ALU and one in-order MEM issue per cycle.
module issue_queue_scheduler
    import issue_queue_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VALID_0,
    input  logic             VALID_1,
    input  task_t            TASK_0,
    input  task_t            TASK_1,
    output logic             ACCEPT_0,
    output logic             ACCEPT_1,
    input  logic             regWrite,
    input  logic [4:0]       regWrite_addr,
    input  logic [31:0]      WB_rfIn,
    input  logic             FLUSH,
    output logic             ALU_VALID,
    input  logic             ALU_READY,
    output task_t            ALU_TASK,
    output logic             MEM_VALID,
    input  logic             MEM_READY,
    output task_t            MEM_TASK,
    output logic [CNT_W-1:0] COUNT
);

    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        q_q [DEPTH];
    iq_entry_t        q_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [31:0]      busy;
    logic [31:0]      busy_now;
    logic [31:0]      wb_vec;
    logic [31:0]      flush_mask;
    logic             alu_found;
    logic             mem_found;
    logic [IDX_W-1:0] alu_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             alu_fire;
    logic             mem_fire;
    logic             t0_writes;
    logic             t1_writes;
    logic             dep1_rs1;
    logic             dep1_rs2;

    function automatic iq_entry_t insert_entry(input task_t t, input logic [31:0] busy_v,
                                               input logic wb, input logic [4:0] wa,
                                               input logic [31:0] wd, input logic hold1,
                                               input logic hold2);
        iq_entry_t e;
        logic      hit1;
        logic      hit2;
        e.t       = t;
        e.valid   = 1'b1;
        hit1      = wb && t.rs1_used && (t.rs1 != 5'd0) && (wa == t.rs1) && !hold1;
        hit2      = wb && t.rs2_used && (t.rs2 != 5'd0) && (wa == t.rs2) && !hold2;
        e.rs1_rdy = !hold1 && (!t.rs1_used || (t.rs1 == 5'd0) || !busy_v[t.rs1] || hit1);
        e.rs2_rdy = !hold2 && (!t.rs2_used || (t.rs2 == 5'd0) || !busy_v[t.rs2] || hit2);
        if (hit1) e.t.A = wd;
        if (hit2) begin
            e.t.rs2_data = wd;
            if (B_FROM_RS2(t.opcode)) e.t.B = wd;
        end
        return e;
    endfunction

    function automatic iq_entry_t snoop_entry(input iq_entry_t e_in, input logic wb,
                                              input logic [4:0] wa, input logic [31:0] wd);
        iq_entry_t e;
        e = e_in;
        if (wb && (wa != 5'd0)) begin
            if (!e.rs1_rdy && (e.t.rs1 == wa)) begin
                e.rs1_rdy = 1'b1;
                e.t.A     = wd;
            end
            if (!e.rs2_rdy && (e.t.rs2 == wa)) begin
                e.rs2_rdy    = 1'b1;
                e.t.rs2_data = wd;
                if (B_FROM_RS2(e.t.opcode)) e.t.B = wd;
            end
        end
        return e;
    endfunction

    // A writeback landing this cycle already frees its register for WAW purposes.
    assign wb_vec    = regWrite ? (32'd1 << regWrite_addr) : 32'd0;
    assign busy_now  = busy & ~wb_vec;
    assign t0_writes = TASK_0.rd_used && (TASK_0.rd != 5'd0);
    assign t1_writes = TASK_1.rd_used && (TASK_1.rd != 5'd0);
    assign dep1_rs1  = t0_writes && TASK_1.rs1_used && (TASK_1.rs1 == TASK_0.rd);
    assign dep1_rs2  = t0_writes && TASK_1.rs2_used && (TASK_1.rs2 == TASK_0.rd);

    assign ACCEPT_0 = VALID_0 && !FLUSH && (count_q < CNT_W'(DEPTH))
                      && !(t0_writes && busy_now[TASK_0.rd]);
    assign ACCEPT_1 = ACCEPT_0 && VALID_1 && (count_q < CNT_W'(DEPTH - 1))
                      && !(t1_writes && (busy_now[TASK_1.rd]
                           || (TASK_0.rd_used && (TASK_0.rd == TASK_1.rd))));

    always_comb begin
        alu_found = 1'b0;
        alu_idx   = '0;
        mem_found = 1'b0;
        mem_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!alu_found && q_q[i].valid && !is_mem(q_q[i].t.opcode)
                && q_q[i].rs1_rdy && q_q[i].rs2_rdy) begin
                alu_found = 1'b1;
                alu_idx   = IDX_W'(i);
            end
            if (!mem_found && q_q[i].valid && is_mem(q_q[i].t.opcode)) begin
                mem_found = 1'b1;
                mem_idx   = IDX_W'(i);
            end
        end
    end

    assign ALU_VALID = alu_found && !FLUSH;
    assign ALU_TASK  = q_q[alu_idx].t;
    assign MEM_VALID = mem_found && q_q[mem_idx].rs1_rdy && q_q[mem_idx].rs2_rdy && !FLUSH;
    assign MEM_TASK  = q_q[mem_idx].t;
    assign alu_fire  = ALU_VALID && ALU_READY;
    assign mem_fire  = MEM_VALID && MEM_READY;
    assign COUNT     = count_q;

    // Survivors are packed toward index 0, then new tasks land behind them.
    always_comb begin
        int n;
        q_d        = '{default: '0};
        flush_mask = '0;
        n          = 0;
        if (FLUSH) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_q[i].valid && q_q[i].t.rd_used) flush_mask[q_q[i].t.rd] = 1'b1;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_q[i].valid && !(alu_fire && (alu_idx == IDX_W'(i)))
                    && !(mem_fire && (mem_idx == IDX_W'(i)))) begin
                    q_d[n] = snoop_entry(q_q[i], regWrite, regWrite_addr, WB_rfIn);
                    n++;
                end
            end
            if (ACCEPT_0 && (n < DEPTH)) begin
                q_d[n] = insert_entry(TASK_0, busy, regWrite, regWrite_addr, WB_rfIn,
                                      1'b0, 1'b0);
                n++;
            end
            if (ACCEPT_1 && (n < DEPTH)) begin
                q_d[n] = insert_entry(TASK_1, busy, regWrite, regWrite_addr, WB_rfIn,
                                      dep1_rs1, dep1_rs2);
                n++;
            end
        end
        count_d = CNT_W'(n);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q     <= '{default: '0};
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk        (CLK),
        .rst_n      (RST_N),
        .set0_en    (ACCEPT_0 && t0_writes),
        .set0_addr  (TASK_0.rd),
        .set1_en    (ACCEPT_1 && t1_writes),
        .set1_addr  (TASK_1.rd),
        .clr_en     (regWrite),
        .clr_addr   (regWrite_addr),
        .flush_mask (flush_mask),
        .busy       (busy)
    );

endmodule
